// File: rtl/geofence_driver.sv
// Streams packed geofence test cases from a synchronous pattern ROM, one 7-word
// case at a time, and scores the geofence result against the expected bit.
module geofence_driver #(
  parameter int NUM_CASES = 50,
  parameter int ADDR_W    = 9,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [9:0]        X,
  output logic [9:0]        Y,
  output logic [10:0]       R,
  input  logic              valid,
  input  logic              is_inside,
  output logic              busy,
  output logic              done,
  output logic [7:0]        pass_cnt,
  output logic [7:0]        fail_cnt,
  output logic              timeout_flag,
  output logic              proto_err,
  output logic [2:0]        dbg_state_o
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  // Handshake: the geofence result is taken only when valid=1 during WAIT;
  // valid in any other state is a protocol error and never scores.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          case_q, case_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                exp_q, exp_d;
  logic [7:0]          pass_q, pass_d;
  logic [7:0]          fail_q, fail_d;
  logic                to_q, to_d;
  logic                perr_q, perr_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic [10:0]         r_q, r_d;
  logic                resolve;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    base_d  = base_q;
    case_d  = case_q;
    wait_d  = wait_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    perr_d  = perr_q;
    x_d     = '0;
    y_d     = '0;
    r_d     = '0;
    resolve = 1'b0;

    // ROM data lags the address by one cycle, so SEND word k carries ROM word k.
    if (state_q == S_SEND) begin
      x_d = mem_rdata[30:21];
      y_d = mem_rdata[20:11];
      r_d = mem_rdata[10:0];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PRIME;
          pass_d  = '0;
          fail_d  = '0;
          to_d    = 1'b0;
          perr_d  = 1'b0;
          case_d  = '0;
          base_d  = '0;
          addr_d  = '0;
        end
      end
      S_PRIME: begin
        addr_d  = addr_q + ADDR_W'(1);
        word_d  = 3'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (word_q == 3'd0) exp_d = mem_rdata[31];
        if (word_q == 3'd6) begin
          base_d  = base_q + ADDR_W'(7);
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          word_d = word_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (valid) begin
          resolve = 1'b1;
          if (is_inside == exp_q) pass_d = sat_inc(pass_q);
          else                    fail_d = sat_inc(fail_q);
        end else if (wait_q == WAIT_W'(TIMEOUT)) begin
          resolve = 1'b1;
          fail_d  = sat_inc(fail_q);
          to_d    = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (resolve) begin
          if (case_q == 8'(NUM_CASES - 1)) begin
            state_d = S_DONE;
          end else begin
            case_d  = case_q + 8'd1;
            addr_d  = base_q;
            state_d = S_PRIME;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (valid && (state_q != S_WAIT)) perr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      case_q  <= '0;
      wait_q  <= '0;
      exp_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      to_q    <= 1'b0;
      perr_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      case_q  <= case_d;
      wait_q  <= wait_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      perr_q  <= perr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
    end
  end

  assign mem_addr     = addr_q;
  assign X            = x_q;
  assign Y            = y_q;
  assign R            = r_q;
  assign busy         = (state_q == S_PRIME) || (state_q == S_SEND) || (state_q == S_WAIT);
  assign done         = (state_q == S_DONE);
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign timeout_flag = to_q;
  assign proto_err    = perr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_geofence_driver.sv
// Bench for geofence_driver: pattern ROM, scripted geofence responder and a
// case-timeline model checked against the DUT on every cycle.
module tb_geofence_driver;

  localparam int N  = 3;
  localparam int AW = 6;
  localparam int TO = 15;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic          is_inside = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [9:0]    X, Y;
  logic [10:0]   R;
  logic          busy, done, timeout_flag, proto_err;
  logic [7:0]    pass_cnt, fail_cnt;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  geofence_driver #(.NUM_CASES(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .X(X), .Y(Y), .R(R),
    .valid(valid), .is_inside(is_inside),
    .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .timeout_flag(timeout_flag), .proto_err(proto_err),
    .dbg_state_o(dbg_state)
  );

  logic [31:0] rom [0:63];
  always @(posedge clk) mem_rdata <= rom[mem_addr];

  // ---------------- model state ----------------
  int m_mode = 0;          // 0 idle, 1 running, 2 done
  int m_t = 0;             // cycle offset in the current case (0 = PRIME)
  int m_case = 0;
  int m_pass = 0, m_fail = 0;
  bit m_to = 0, m_proto = 0;
  bit m_addr0 = 1;         // mem_addr known to be 0 (after reset, before a run)

  int lat [N];             // WAIT cycle of the geofence answer, -1 = never
  bit resp [N];
  int inj_v_case = -1, inj_v_t = -1;
  int inj_r_case = -1, inj_r_t = -1;
  int inj_s_t = -1;
  bit pin_first = 0;
  int busy_cnt = 0;

  int n_cmp = 0, n_bad = 0;

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] w;
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("pass_cnt", 32'(pass_cnt), 32'(m_pass));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    chk("timeout_flag", 32'(timeout_flag), 32'(m_to));
    chk("proto_err", 32'(proto_err), 32'(m_proto));
    w = 32'd0;
    if (m_mode == 1 && m_t >= 2 && m_t <= 8) w = rom[7 * m_case + m_t - 2];
    chk("X", 32'(X), 32'(w[30:21]));
    chk("Y", 32'(Y), 32'(w[20:11]));
    chk("R", 32'(R), 32'(w[10:0]));
    if (m_mode == 1 && m_t <= 7) chk("mem_addr", 32'(mem_addr), 32'(7 * m_case + m_t));
    else if (m_addr0)            chk("mem_addr_rst", 32'(mem_addr), 32'd0);
    if (pin_first && m_mode == 1 && m_case == 0 && m_t == 2) begin
      chk("lit_X0", 32'(X), 32'd100);
      chk("lit_Y0", 32'(Y), 32'd200);
      chk("lit_R0", 32'(R), 32'd0);
    end
    if (pin_first && m_mode == 1 && m_t == 0 && m_case == 1) chk("lit_addr_c2", 32'(mem_addr), 32'd7);
    if (pin_first && m_mode == 1 && m_t == 0 && m_case == 2) chk("lit_addr_c3", 32'(mem_addr), 32'd14);
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic resolve_case();
    if (m_case == N - 1) m_mode = 2;
    else begin
      m_case++;
      m_t = 0;
    end
  endtask

  task automatic model_step(input bit rs_n, input bit st, input bit v, input bit iv);
    if (!rs_n) begin
      m_mode = 0; m_t = 0; m_case = 0; m_pass = 0; m_fail = 0;
      m_to = 0; m_proto = 0; m_addr0 = 1;
      return;
    end
    if (m_mode != 1) begin
      if (st) begin
        m_mode = 1; m_t = 0; m_case = 0; m_pass = 0; m_fail = 0;
        m_to = 0; m_proto = 0; m_addr0 = 0;
      end
      if (v) m_proto = 1;
    end else if (m_t < 8) begin
      if (v) m_proto = 1;
      m_t++;
    end else if (v) begin
      if (iv == rom[7 * m_case][31]) m_pass = sat(m_pass);
      else                           m_fail = sat(m_fail);
      resolve_case();
    end else if (m_t - 8 == TO) begin
      m_fail = sat(m_fail);
      m_to = 1;
      resolve_case();
    end else begin
      m_t++;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit rs_n, input bit st, input bit xv);
    bit rv;
    @(negedge clk);
    check_outputs();
    if (busy === 1'b1) busy_cnt++;
    rv = (m_mode == 1) && (m_t >= 8) && (lat[m_case] >= 0) && (m_t - 8 == lat[m_case]);
    reset     = rs_n;
    start     = st;
    valid     = rv | xv;
    is_inside = rv ? resp[m_case] : 1'($urandom_range(0, 1));
    model_step(rs_n, st, rv | xv, is_inside);
  endtask

  task automatic run(input int max_cyc);
    bit rs_n, st, xv;
    cycle(1, 1, 0);
    for (int i = 0; i < max_cyc && m_mode == 1; i++) begin
      rs_n = !(m_case == inj_r_case && m_t == inj_r_t);
      st   = (m_case == 0 && m_t == inj_s_t);
      xv   = (m_case == inj_v_case && m_t == inj_v_t);
      cycle(rs_n, st, xv);
    end
    cycle(1, 0, 0);
  endtask

  task automatic set_case(input int c, input int l, input bit r);
    lat[c]  = l;
    resp[c] = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0]  = 32'h8C86_4000;              // expected 1, X=100 Y=200 R=0
    rom[7]  = rom[7]  & 32'h7FFF_FFFF;    // expected 0
    rom[14] = rom[14] | 32'h8000_0000;    // expected 1

    // reset held with start=1, then released with start low
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("lit_idle_busy", 32'(busy), 32'd0);

    // run A: scoring, second case mismatches
    pin_first = 1;
    set_case(0, 3, 1); set_case(1, 5, 1); set_case(2, 0, 1);
    run(200);
    pin_first = 0;
    chk("lit_A_pass", 32'(pass_cnt), 32'd2);
    chk("lit_A_fail", 32'(fail_cnt), 32'd1);
    chk("lit_A_done", 32'(done), 32'd1);

    // run B: geofence never answers
    set_case(0, -1, 0); set_case(1, -1, 0); set_case(2, -1, 0);
    busy_cnt = 0;
    run(200);
    chk("lit_B_cycles", 32'(busy_cnt), 32'd72);
    chk("lit_B_fail", 32'(fail_cnt), 32'd3);
    chk("lit_B_to", 32'(timeout_flag), 32'd1);
    cycle(1, 0, 1);                       // valid while DONE
    cycle(1, 0, 0);
    chk("lit_B_perr", 32'(proto_err), 32'd1);
    chk("lit_B_fail2", 32'(fail_cnt), 32'd3);

    // run C: stray valid in SEND word 3, valid on the timeout cycle
    set_case(0, TO, 1); set_case(1, 2, 0); set_case(2, TO, 0);
    inj_v_case = 0; inj_v_t = 4;
    run(200);
    inj_v_case = -1; inj_v_t = -1;
    chk("lit_C_pass", 32'(pass_cnt), 32'd2);
    chk("lit_C_fail", 32'(fail_cnt), 32'd1);
    chk("lit_C_to", 32'(timeout_flag), 32'd0);
    chk("lit_C_perr", 32'(proto_err), 32'd1);

    // run D: start while busy ignored, reset during WAIT of case 2
    set_case(0, 1, 1); set_case(1, 6, 0); set_case(2, 1, 1);
    inj_s_t = 3; inj_r_case = 1; inj_r_t = 10;
    run(200);
    inj_s_t = -1; inj_r_case = -1; inj_r_t = -1;
    chk("lit_D_busy", 32'(busy), 32'd0);
    chk("lit_D_pass", 32'(pass_cnt), 32'd0);
    chk("lit_D_X", 32'(X), 32'd0);
    chk("lit_D_addr", 32'(mem_addr), 32'd0);

    // replay from address 0
    set_case(0, 1, 1); set_case(1, 1, 0); set_case(2, 1, 1);
    run(200);
    chk("lit_E_pass", 32'(pass_cnt), 32'd3);
    chk("lit_E_fail", 32'(fail_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
